// File: rtl/btb_pred.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookups are registered (1-cycle latency) and read pre-edge table state; one update per cycle.
module btb_pred #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            flush
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [TAG_W-1:0]    tag_d [ENTRIES];
  logic [XLEN-1:0]     tgt_q [ENTRIES];
  logic [XLEN-1:0]     tgt_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];

  logic            pred_valid_q, pred_valid_d;
  logic            pred_hit_q, pred_hit_d;
  logic            pred_taken_q, pred_taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;

  logic [IDX-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             upd_pc_unused;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign upd_pc_unused = ^upd_pc[1:0];

  // Prediction is formed from the table as it stood before this edge's update.
  always_comb begin
    pred_valid_d  = lookup_valid;
    pred_hit_d    = 1'b0;
    pred_taken_d  = 1'b0;
    pred_target_d = '0;
    if (lookup_valid) begin
      pred_hit_d    = lk_hit;
      pred_taken_d  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
      pred_target_d = lk_hit ? tgt_q[lk_idx] : lookup_pc + XLEN'(4);
    end
  end

  // Flush takes priority and discards any concurrent training update.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != CTR_MAX) ctr_d[up_idx] = ctr_q[up_idx] + CTR_BITS'(1);
          tgt_d[up_idx] = upd_target;
        end else if (ctr_q[up_idx] != '0) begin
          ctr_d[up_idx] = ctr_q[up_idx] - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = upd_target;
        ctr_d[up_idx]   = CTR_WEAK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  // Tags and targets are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;

endmodule
